fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the asynchronous FIFO among NUM_REQ packet requesters.
- Sits entirely in the FIFO write-clock domain.
- Drives the FIFO w_en/data_in and observes the FIFO full flag.
- Grants one requester at a time and holds the grant until that requester's packet ends or a burst limit is reached, so packets never interleave in the FIFO.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- WIDTH, 8, data width; equals the FIFO WIDTH.
- MAX_BURST, 0, maximum beats per grant; 0 means unlimited (grant held until last).

Ports:
- clk  input  1  write-domain clock, same clock as FIFO w_clk.
- rst  input  1  reset, synchronous, active-high.
- req  input  NUM_REQ  per-requester "beat valid"; held high until the beat is accepted.
- req_data  input  NUM_REQ*WIDTH  flattened data; requester i occupies bits [i*WIDTH +: WIDTH].
- req_last  input  NUM_REQ  marks the final beat of a packet.
- ready  output  NUM_REQ  per-requester accept; a beat transfers when req[i] && ready[i].
- fifo_full  input  1  FIFO full flag.
- fifo_w_en  output  1  FIFO write enable.
- fifo_data_in  output  WIDTH  FIFO write data.
- grant_id  output  $clog2(NUM_REQ)  index of the current owner; valid when busy.
- busy  output  1  high while in XFER.

Behaviour:
- Single clock; reset is synchronous and active-high.
- Reset values:
  - state=IDLE; rr_ptr=NUM_REQ-1, so requester 0 wins first.
  - grant_id=0, busy=0, beat_cnt=0.
  - ready=0, fifo_w_en=0.
  - fifo_data_in = requester-0 data (mux output, don't-care).
- State IDLE:
  - ready=0, fifo_w_en=0.
  - If |req, pick the first asserted req searching upward from rr_ptr+1 (mod NUM_REQ).
  - Register the winner into grant_id, clear beat_cnt, go to XFER.
  - Arbitration latency is 1 cycle: IDLE→XFER always costs exactly one bubble cycle.
- State XFER (owner g = grant_id):
  - ready[g] = !fifo_full; all other ready bits are 0. ready is combinational from fifo_full.
  - fifo_w_en = req[g] && !fifo_full.
  - fifo_data_in = req_data[g] (combinational mux).
  - Accepted beat: beat_cnt increments.
  - End of grant when an accepted beat has req_last[g]=1, or (MAX_BURST!=0 && beat_cnt==MAX_BURST-1). Then rr_ptr<=g and state<=IDLE.
- fifo_full high: no beat accepted and no write issued; state and counters hold. There is no overflow path.
- Owner deasserts req mid-packet: grant is held and the arbiter waits; other requesters stay blocked.
- Non-owner req changes while in XFER: ignored.
- A requester truncated by MAX_BURST re-arbitrates normally; its packet continues at its next grant.
- Single beat with req_last: 2 cycles per packet (IDLE + XFER).
- beat_cnt width is $clog2(MAX_BURST+1), minimum 1. It does not wrap when MAX_BURST=0; it saturates.
- Reset mid-packet: returns to IDLE on the next edge. The FIFO is not flushed; the partial packet stays in it.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- Defined:
  - Adds output beat_count of NUM_REQ*16 bits, one 16-bit saturating counter per requester.
  - A counter increments on each accepted beat of its requester.
  - Counters clear on rst and hold at 16'hFFFF when saturated.
- Undefined: the port and counters are absent. Functional behaviour is otherwise identical.

Decomposition:
- Package fifo_arb_pkg contains:
  - state typedef enum {IDLE, XFER}.
  - Localparam helper for ID width ($clog2 with minimum 1).
  - Stats counter width constant (16).
- Sub-module rr_pick is natural: a combinational round-robin priority picker with inputs req[NUM_REQ] and ptr, and outputs winner id and any_req.

Test Plan:
- Reset, then req=4'b0001 with a 3-beat packet 0xA1,0xA2,0xA3 (last on 3rd) → FIFO receives A1,A2,A3 on 3 consecutive cycles starting 1 cycle after req; busy drops the cycle after A3.
- req=4'b1111, each requester sends a 1-beat packet → grant order 0,1,2,3; 8 cycles total; rr_ptr ends at 3.
- Owner 2 mid-packet, fifo_full asserted for 5 cycles → fifo_w_en=0 and ready=0 for those 5 cycles; no data lost or duplicated; transfer resumes on the first non-full cycle.
- MAX_BURST=2, requester 0 sends a 5-beat packet while requester 1 is waiting → sequence 0,0,1…,0,0,…,0 with grants alternating; per-requester beat order is preserved.
- Owner 1 drops req for 3 cycles mid-packet while req[3]=1 → grant stays 1; no writes from requester 3 until requester 1's last beat.
- Assert rst during XFER → next cycle busy=0, ready=0, fifo_w_en=0; after reset release, requester 0 wins first. With FIFO_ARB_STATS_EN: counters read 0 after reset and saturate at 0xFFFF after 65535+ beats.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
// Pure declarations: no logic, no latency, no backpressure.
// Imported by rr_pick and fifo_wr_arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int STATS_W = 16;

    // Index width for n requesters; a lone requester still needs one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: first set req bit searching upward from ptr+1.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the winner is consumed.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IW      = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      winner,
    output logic               any_req
);

    logic [IW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest request overwrites last.
    always_comb begin
        winner  = '0;
        idx     = '0;
        any_req = |req;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IW'((int'(ptr) + k) % NUM_REQ);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin sharing of one FIFO write port; grant held per packet or MAX_BURST beats; FIFO_ARB_STATS_EN adds per-requester beat counters.
// Latency: one bubble cycle to arbitrate, then one beat per cycle straight to the FIFO.
// Backpressure: fifo_full combinationally drops the owner's ready and w_en; state holds.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int WIDTH     = 8,
    parameter  int MAX_BURST = 0,
    localparam int IW        = id_w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       ready,
    input  logic                     fifo_full,
    output logic                     fifo_w_en,
    output logic [WIDTH-1:0]         fifo_data_in,
    output logic [IW-1:0]            grant_id,
    output logic                     busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STATS_W-1:0] beat_count
`endif
);

    localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    arb_state_t    state, state_nxt;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] win_id;
    logic          any_req;
    logic          accept;
    logic          end_grant;
    logic [BW-1:0] beat_cnt;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req     (req),
        .ptr     (rr_ptr),
        .winner  (win_id),
        .any_req (any_req)
    );

    assign busy         = (state == XFER);
    assign fifo_data_in = req_data[grant_id*WIDTH +: WIDTH];

    always_comb begin
        state_nxt = state;
        ready     = '0;
        fifo_w_en = 1'b0;
        accept    = 1'b0;
        end_grant = 1'b0;
        if (state == XFER) begin
            ready[grant_id] = !fifo_full;
            accept          = req[grant_id] && !fifo_full;
            fifo_w_en       = accept;
            end_grant       = accept && (req_last[grant_id] ||
                              (MAX_BURST != 0 && beat_cnt == BW'(MAX_BURST - 1)));
            if (end_grant) begin
                state_nxt = IDLE;
            end
        end else if (any_req) begin
            state_nxt = XFER;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= IW'(NUM_REQ - 1);
            grant_id <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                grant_id <= win_id;
                beat_cnt <= '0;
            end else if (accept && beat_cnt != '1) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (end_grant) begin
                rr_ptr <= grant_id;
            end
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [STATS_W-1:0] stat_cnt [NUM_REQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_cnt[i] <= '0;
            end
        end else if (accept && stat_cnt[grant_id] != '1) begin
            stat_cnt[grant_id] <= stat_cnt[grant_id] + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            beat_count[i*STATS_W +: STATS_W] = stat_cnt[i];
        end
    end
`endif

endmodule
